win_scanner: RTL and testbench

//  Sequential five-in-a-row detector downstream of the board store. It replaces the

---
 rtl/win_scanner_if.sv | 24 ++
 rtl/win_scanner.sv | 179 +++++++++++++++++
 tb/tb_win_scanner.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/win_scanner_if.sv
// Handshake and board bus between the board store (master) and the win scanner (slave).
// Carries the start/clear controls, the placed position, the live board and the scan results.
interface win_scanner_if #(
    parameter int N = 10
);
    logic               clear;
    logic               start;
    logic [7:0]         pos;
    logic [2*N*N-1:0]   board_state;
    logic               busy;
    logic               done;
    logic               black_win;
    logic               white_win;

    modport master (
        output clear, start, pos, board_state,
        input  busy, done, black_win, white_win
    );

    modport slave (
        input  clear, start, pos, board_state,
        output busy, done, black_win, white_win
    );
endinterface

// File: rtl/win_scanner.sv
// Sequential five-in-a-row detector: walks outward from the stone just placed,
// one cell per clock, in four directions, and raises sticky win flags.
module win_scanner #(
    parameter int N       = 10,
    parameter int WIN_LEN = 5
) (
    input  logic          clk,
    input  logic          rst,
    win_scanner_if.slave  bus
);
    localparam int               CELLS = N * N;
    localparam int               IW    = $clog2(CELLS);
    localparam logic [7:0]       N8    = 8'(N);
    localparam logic [7:0]       CELLS8 = 8'(CELLS);
    localparam logic signed [4:0] N_S  = 5'(N);
    localparam logic [3:0]       WIN4  = 4'(WIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_FWD, S_BWD, S_EVAL, S_DONE
    } state_t;

    state_t             state_reg;
    logic [7:0]         pos_reg;
    logic signed [4:0]  row_reg;
    logic signed [4:0]  col_reg;
    logic [1:0]         colour_reg;
    logic [1:0]         dir_reg;
    logic [3:0]         count_reg;
    logic [2:0]         step_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               black_win_reg;
    logic               white_win_reg;

    // Board unpacked into per-cell entries so both probes below are plain muxes.
    logic [1:0] cells [CELLS];
    genvar gi;
    generate
        for (gi = 0; gi < CELLS; gi++) begin : g_cells
            assign cells[gi] = bus.board_state[2*gi +: 2];
        end
    endgenerate

    // Placed-stone decode used while in LOAD.
    logic [7:0] pos_row;
    logic [7:0] pos_col;
    logic       pos_valid;
    logic [1:0] pos_cell;

    always_comb begin
        pos_row   = pos_reg / N8;
        pos_col   = pos_reg % N8;
        pos_valid = (pos_reg < CELLS8);
        pos_cell  = pos_valid ? cells[pos_reg[IW-1:0]] : 2'b00;
    end

    // Probe cell at distance step along the current direction; BWD mirrors FWD.
    logic signed [4:0] base_dr;
    logic signed [4:0] base_dc;
    logic signed [4:0] step_dr;
    logic signed [4:0] step_dc;
    logic signed [4:0] step_s;
    logic signed [4:0] probe_row;
    logic signed [4:0] probe_col;
    logic              probe_in;
    logic [IW-1:0]     probe_idx;
    logic [1:0]        probe_cell;
    logic              hit;

    always_comb begin
        base_dr = 5'sd0;
        base_dc = 5'sd0;
        case (dir_reg)
            2'd0:    base_dc = 5'sd1;
            2'd1:    base_dr = 5'sd1;
            2'd2:    begin base_dr = 5'sd1; base_dc = 5'sd1;  end
            default: begin base_dr = 5'sd1; base_dc = -5'sd1; end
        endcase
        step_dr   = (state_reg == S_BWD) ? -base_dr : base_dr;
        step_dc   = (state_reg == S_BWD) ? -base_dc : base_dc;
        step_s    = $signed({2'b00, step_reg});
        probe_row = row_reg + step_dr * step_s;
        probe_col = col_reg + step_dc * step_s;
        // Bounds are per axis, so a line can never wrap onto the next row.
        probe_in  = !probe_row[4] && (probe_row < N_S) && !probe_col[4] && (probe_col < N_S);
        probe_idx = IW'(32'(probe_row[3:0]) * 32'(N) + 32'(probe_col[3:0]));
        probe_cell = probe_in ? cells[probe_idx] : 2'b00;
        hit       = probe_in && (probe_cell == colour_reg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            pos_reg       <= 8'd0;
            row_reg       <= 5'sd0;
            col_reg       <= 5'sd0;
            colour_reg    <= 2'b00;
            dir_reg       <= 2'd0;
            count_reg     <= 4'd1;
            step_reg      <= 3'd1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            black_win_reg <= 1'b0;
            white_win_reg <= 1'b0;
        end else if (bus.clear) begin
            state_reg     <= S_IDLE;
            dir_reg       <= 2'd0;
            count_reg     <= 4'd1;
            step_reg      <= 3'd1;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            black_win_reg <= 1'b0;
            white_win_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start && !black_win_reg && !white_win_reg) begin
                        pos_reg   <= bus.pos;
                        busy_reg  <= 1'b1;
                        state_reg <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    row_reg    <= $signed(pos_row[4:0]);
                    col_reg    <= $signed(pos_col[4:0]);
                    colour_reg <= pos_cell;
                    if (!pos_valid || !pos_cell[1]) begin
                        state_reg <= S_DONE;
                    end else begin
                        dir_reg   <= 2'd0;
                        count_reg <= 4'd1;
                        step_reg  <= 3'd1;
                        state_reg <= S_FWD;
                    end
                end
                S_FWD, S_BWD: begin
                    if (hit) begin
                        count_reg <= count_reg + 4'd1;
                    end
                    if (!hit || step_reg == 3'd4) begin
                        step_reg  <= 3'd1;
                        state_reg <= (state_reg == S_FWD) ? S_BWD : S_EVAL;
                    end else begin
                        step_reg  <= step_reg + 3'd1;
                    end
                end
                S_EVAL: begin
                    if (count_reg >= WIN4) begin
                        if (colour_reg[0]) begin
                            white_win_reg <= 1'b1;
                        end else begin
                            black_win_reg <= 1'b1;
                        end
                        state_reg <= S_DONE;
                    end else if (dir_reg == 2'd3) begin
                        state_reg <= S_DONE;
                    end else begin
                        dir_reg   <= dir_reg + 2'd1;
                        count_reg <= 4'd1;
                        step_reg  <= 3'd1;
                        state_reg <= S_FWD;
                    end
                end
                S_DONE: begin
                    done_reg  <= 1'b1;
                    busy_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.black_win = black_win_reg;
    assign bus.white_win = white_win_reg;
endmodule

// File: tb/tb_win_scanner.sv
// Bench for win_scanner: directed scenarios plus randomized boards, each scan
// compared against a line-counting reference model of the game rules.
`timescale 1ns/1ps
module tb_win_scanner;
    localparam int N = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    win_scanner_if #(.N(N)) bus ();

    win_scanner #(.N(N), .WIN_LEN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [1:0] brd [N*N];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Consecutive stones of colour col starting one step away, capped at 4.
    function automatic int run_len(input int r, input int c, input int dr, input int dc,
                                   input logic [1:0] col);
        int n;
        int rr;
        int cc;
        n = 0;
        for (int s = 1; s <= 4; s++) begin
            rr = r + s * dr;
            cc = c + s * dc;
            if (rr < 0 || rr >= N || cc < 0 || cc >= N) break;
            if (brd[rr*N + cc] !== col) break;
            n++;
        end
        return n;
    endfunction

    // win: 0 none, 1 black, 2 white. lat: cycles from acceptance to the done pulse.
    function automatic void model(input int p, output int win, output int lat);
        logic [1:0] col;
        int r, c, dr, dc, f, b;
        win = 0;
        lat = 2;
        if (p >= N*N) return;
        col = brd[p];
        if (col != 2'b10 && col != 2'b11) return;
        r = p / N;
        c = p % N;
        for (int d = 0; d < 4; d++) begin
            dr = (d == 0) ? 0 : 1;
            dc = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
            f = run_len(r, c, dr, dc, col);
            b = run_len(r, c, -dr, -dc, col);
            lat += ((f == 4) ? 4 : f + 1) + ((b == 4) ? 4 : b + 1) + 1;
            if (1 + f + b >= 5) begin
                win = (col == 2'b11) ? 2 : 1;
                return;
            end
        end
    endfunction

    task automatic clear_board();
        for (int k = 0; k < N*N; k++) brd[k] = 2'b00;
    endtask

    task automatic put_line(input int r0, input int c0, input int dr, input int dc,
                            input int len, input logic [1:0] col);
        int rr, cc;
        for (int i = 0; i < len; i++) begin
            rr = r0 + i * dr;
            cc = c0 + i * dc;
            if (rr >= 0 && rr < N && cc >= 0 && cc < N) brd[rr*N + cc] = col;
        end
    endtask

    task automatic load_board();
        for (int k = 0; k < N*N; k++) bus.board_state[2*k +: 2] = brd[k];
    endtask

    task automatic do_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic run_scan(input string tag, input int p);
        int win_exp, lat_exp, e;
        bit seen, busy_low;
        model(p, win_exp, lat_exp);
        load_board();
        @(negedge clk);
        bus.pos   = 8'(p);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy_rise"}, int'(bus.busy), 1);
        e = 0;
        seen = 0;
        busy_low = 0;
        while (e < 60) begin
            @(negedge clk);
            e++;
            if (bus.done) begin
                seen = 1;
                break;
            end
            if (!bus.busy) busy_low = 1;
        end
        chk({tag, "_latency"}, seen ? e : -1, lat_exp);
        chk({tag, "_busy_held"}, int'(busy_low), 0);
        chk({tag, "_black"}, int'(bus.black_win), (win_exp == 1) ? 1 : 0);
        chk({tag, "_white"}, int'(bus.white_win), (win_exp == 2) ? 1 : 0);
        chk({tag, "_busy_end"}, int'(bus.busy), 0);
        @(negedge clk);
        chk({tag, "_done_pulse"}, int'(bus.done), 0);
        $display("scan %s pos=%0d lat=%0d exp_lat=%0d black=%0d white=%0d exp_win=%0d",
                 tag, p, e, lat_exp, bus.black_win, bus.white_win, win_exp);
    endtask

    // Start a scan and return once e cycles have elapsed since acceptance.
    task automatic start_and_wait(input int p, input int cycles);
        load_board();
        @(negedge clk);
        bus.pos   = 8'(p);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < cycles; i++) @(negedge clk);
    endtask

    initial begin
        int p, d, len, off, v, dr, dc;
        bit seen;
        logic [1:0] col;

        bus.clear       = 1'b0;
        bus.start       = 1'b0;
        bus.pos         = 8'd0;
        bus.board_state = '0;
        clear_board();

        repeat (2) @(negedge clk);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_black", int'(bus.black_win), 0);
        chk("rst_white", int'(bus.white_win), 0);

        // Five black in a row.
        clear_board();
        put_line(4, 2, 0, 1, 5, 2'b10);
        run_scan("t1", 46);
        do_clear();
        chk("t1_clear_flag", int'(bus.black_win), 0);

        // Four only.
        clear_board();
        put_line(4, 2, 0, 1, 4, 2'b10);
        run_scan("t2", 45);
        do_clear();

        // Linear run across a row boundary, then a white anti-diagonal.
        clear_board();
        for (int k = 27; k <= 31; k++) brd[k] = 2'b10;
        run_scan("t3a", 29);
        do_clear();
        clear_board();
        put_line(0, 9, 1, -1, 5, 2'b11);
        run_scan("t3b", 27);
        do_clear();

        // Overline, then a start that must be ignored while a flag is up.
        clear_board();
        put_line(4, 0, 0, 1, 6, 2'b10);
        run_scan("t4", 42);
        @(negedge clk);
        bus.pos   = 8'd42;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("t4_ignored_busy", int'(bus.busy), 0);
        seen = 0;
        repeat (45) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen = 1;
        end
        chk("t4_ignored_activity", int'(seen), 0);
        chk("t4_flag_held", int'(bus.black_win), 1);
        do_clear();

        // Empty and out-of-board cells.
        clear_board();
        run_scan("t5a", 0);
        run_scan("t5b", 120);

        // Clear in the middle of a scan.
        clear_board();
        put_line(4, 2, 0, 1, 4, 2'b10);
        start_and_wait(45, 9);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("t6_clear_busy", int'(bus.busy), 0);
        chk("t6_clear_done", int'(bus.done), 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        chk("t6_clear_no_done", int'(seen), 0);

        // Asynchronous reset in the middle of a scan.
        clear_board();
        put_line(4, 2, 0, 1, 4, 2'b10);
        start_and_wait(45, 5);
        chk("t6_pre_rst_busy", int'(bus.busy), 1);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_busy", int'(bus.busy), 0);
        chk("t6_rst_done", int'(bus.done), 0);
        chk("t6_rst_flags", int'({bus.black_win, bus.white_win}), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized boards, often with a planted line through the placed stone.
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < N*N; k++) begin
                v = int'($urandom_range(0, 3));
                brd[k] = (v < 2) ? 2'b00 : (v == 2) ? 2'b10 : 2'b11;
            end
            p = ($urandom_range(0, 9) == 0) ? int'($urandom_range(100, 255))
                                            : int'($urandom_range(0, 99));
            if (p < N*N && $urandom_range(0, 2) != 0) begin
                col = (brd[p] == 2'b00) ? 2'b11 : brd[p];
                d   = int'($urandom_range(0, 3));
                dr  = (d == 0) ? 0 : 1;
                dc  = (d == 0) ? 1 : (d == 1) ? 0 : (d == 2) ? 1 : -1;
                len = int'($urandom_range(3, 6));
                off = int'($urandom_range(0, len - 1));
                put_line(p / N - off * dr, p % N - off * dc, dr, dc, len, col);
            end
            run_scan($sformatf("rnd%0d", it), p);
            do_clear();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
